elevator_queue_dispatcher: RTL and testbench
============================================

// Module: elevator_queue_dispatcher
// PURPOSE
//  Consumer end of the 16x4 floor-request queue RAM (append-to-first-empty writer, head at word 0, 0 = empty).
//  Reads the head request, drives the car floor by floor to the target floor, and holds the door open.
//  Then pulses shift to pop the head. Sits between the request queue and the car/door/display outputs.
// PARAMETERS
//  TRAVEL_CYCLES  4   clk cycles to move one floor (>=1)
//  DOOR_CYCLES    3   clk cycles door stays open (>=1)
//  MAX_FLOOR      15  highest valid floor; head values above it are dropped
//  RESET_FLOOR    1   car floor after reset (1..MAX_FLOOR)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  q_data       in   4  queue read data (head word); 0 = queue empty
//  q_addr       out  4  queue read address; constant 4'd0
//  q_shift      out  1  one-cycle pop strobe to queue shift input
//  cur_floor    out  4  current car floor
//  moving_up    out  1  car travelling up
//  moving_down  out  1  car travelling down
//  door_open    out  1  door open
//  busy         out  1  high in every state except IDLE
//  req_drop     out  1  one-cycle pulse: invalid head discarded
// BEHAVIOUR
//  All outputs are registered.
//  Reset values: cur_floor=RESET_FLOOR; all 1-bit outputs 0; state IDLE; timer 0; tgt 0.
//  q_data is valid one cycle after a queue edge. A shift takes effect at the edge where q_shift is sampled;
//  the new head is visible on the following cycle.
//  FSM:
//   IDLE:   if q_data!=0, latch tgt<=q_data and go to DECIDE; else stay in IDLE.
//   DECIDE: tgt>MAX_FLOOR -> POP with req_drop=1 (same cycle as q_shift); tgt==cur_floor -> DOOR;
//           tgt>cur_floor -> UP; tgt<cur_floor -> DOWN. Load timer on every exit.
//   UP/DOWN: moving_up/moving_down=1. Timer counts TRAVEL_CYCLES; at expiry cur_floor+=1 / -=1.
//           If the new floor==tgt go to DOOR, else reload timer and stay.
//           cur_floor is never driven past MAX_FLOOR or below 1.
//   DOOR:   door_open=1 for exactly DOOR_CYCLES cycles, then go to POP. Moving flags are 0.
//   POP:    q_shift=1 for exactly one cycle, then go to SETTLE.
//   SETTLE: one cycle for the shifted head to appear, then go to IDLE.
//  At most one of moving_up, moving_down, door_open is high at any time.
//  Exactly one q_shift pulse per accepted head. q_shift is never high on consecutive cycles.
//  Latency from a nonzero head in IDLE to door_open with tgt==cur_floor: 2 cycles.
//  q_data is ignored outside IDLE; tgt is stable from DECIDE through POP.
//  Reset mid-operation: immediate return to reset values. No pop is issued, and the head is re-served after reset.
// CONFIGURATION
//  DISPATCH_DOOR_HOLD_EN defined:
//   adds input door_hold (1 bit). While door_hold=1 in DOOR, the door timer reloads to DOOR_CYCLES,
//   so the door closes DOOR_CYCLES cycles after door_hold falls. door_hold has no effect outside DOOR.
//  DISPATCH_DOOR_HOLD_EN undefined:
//   the door_hold port does not exist, and the door always closes after DOOR_CYCLES.
// TESTING (TRAVEL_CYCLES=4, DOOR_CYCLES=3, MAX_FLOOR=15, RESET_FLOOR=1)
//  Reset: assert reset async mid-cycle -> cur_floor=1; all flags, q_shift and req_drop 0; q_addr=0.
//  Up trip: head=4 at floor 1 -> moving_up 12 cycles (cur_floor 2,3,4 every 4 cycles); door_open 3 cycles;
//   q_shift 1 cycle; then busy=0 with head=0.
//  Down trip: head=2 at floor 4 -> moving_down 8 cycles; cur_floor=2; door 3 cycles; single pop.
//  Same floor plus drop: head=1 at floor 1 -> no motion, door 3 cycles, pop.
//   With MAX_FLOOR=8, head=12 -> req_drop and q_shift same cycle, cur_floor unchanged, no door.
//  Back-to-back: queue {3,1} -> serve 3, pop, SETTLE, serve 1. Exactly 2 q_shift pulses, never adjacent.
//  Reset while moving_up mid-timer -> outputs reset, no q_shift.
//   With DISPATCH_DOOR_HOLD_EN, door_hold high 5 cycles from door entry -> door_open 8 cycles.

Source files
------------

// File: rtl/elevator_queue_dispatcher.sv
// ============================================================================
// Module   : elevator_queue_dispatcher
// Purpose  : Consumer side of the 16x4 floor-request queue. Reads the head
//            word at address 0, drives the car one floor at a time to the
//            requested floor, holds the door open and then pops the head
//            with a single-cycle shift strobe. Head values above MAX_FLOOR
//            are popped without moving and flagged on req_drop.
// Options  : DISPATCH_DOOR_HOLD_EN - adds a door_hold input that keeps the
//            door open while high (timer reloads every cycle it is asserted).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_queue_dispatcher #(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3,
    parameter int unsigned MAX_FLOOR     = 15,
    parameter int unsigned RESET_FLOOR   = 1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef DISPATCH_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    input  logic [3:0] q_data,
    output logic [3:0] q_addr,
    output logic       q_shift,
    output logic [3:0] cur_floor,
    output logic       moving_up,
    output logic       moving_down,
    output logic       door_open,
    output logic       busy,
    output logic       req_drop
);

    // Timer is wide enough for the longer of the two dwell periods.
    localparam int unsigned c_timer_max = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned c_tw        = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;

    // Timers count down from load value to zero, so a load of N-1 gives N cycles.
    localparam logic [c_tw-1:0] c_travel_load   = c_tw'(TRAVEL_CYCLES - 1);
    localparam logic [c_tw-1:0] c_door_load     = c_tw'(DOOR_CYCLES - 1);
    localparam logic [3:0]      c_max_floor     = 4'(MAX_FLOOR);
    localparam logic [4:0]      c_max_floor_ext = 5'(MAX_FLOOR);
    localparam logic [3:0]      c_reset_floor   = 4'(RESET_FLOOR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECIDE = 3'd1,
        S_UP     = 3'd2,
        S_DOWN   = 3'd3,
        S_DOOR   = 3'd4,
        S_POP    = 3'd5,
        S_SETTLE = 3'd6
    } state_t;

    state_t          r_state;
    logic [3:0]      r_tgt;
    logic [c_tw-1:0] r_timer;

    logic            w_tgt_invalid;
    logic [3:0]      w_floor_up;
    logic [3:0]      w_floor_dn;

    // The head word is always read from the front of the queue.
    assign q_addr = 4'd0;

    // Extended compare so a MAX_FLOOR of 15 does not collapse into a constant.
    assign w_tgt_invalid = ({1'b0, r_tgt} > c_max_floor_ext);

    // Saturating floor steps keep the car inside 1..MAX_FLOOR.
    assign w_floor_up = (cur_floor >= c_max_floor) ? cur_floor : cur_floor + 4'd1;
    assign w_floor_dn = (cur_floor <= 4'd1)        ? cur_floor : cur_floor - 4'd1;

    // Dispatcher FSM; every output is registered alongside the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tgt       <= 4'd0;
            r_timer     <= '0;
            cur_floor   <= c_reset_floor;
            q_shift     <= 1'b0;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            busy        <= 1'b0;
            req_drop    <= 1'b0;
        end else begin
            q_shift  <= 1'b0;
            req_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (q_data != 4'd0) begin
                        r_tgt   <= q_data;
                        r_state <= S_DECIDE;
                        busy    <= 1'b1;
                    end
                end

                S_DECIDE: begin
                    if (w_tgt_invalid) begin
                        r_state  <= S_POP;
                        r_timer  <= '0;
                        q_shift  <= 1'b1;
                        req_drop <= 1'b1;
                    end else if (r_tgt == cur_floor) begin
                        r_state   <= S_DOOR;
                        r_timer   <= c_door_load;
                        door_open <= 1'b1;
                    end else if (r_tgt > cur_floor) begin
                        r_state   <= S_UP;
                        r_timer   <= c_travel_load;
                        moving_up <= 1'b1;
                    end else begin
                        r_state     <= S_DOWN;
                        r_timer     <= c_travel_load;
                        moving_down <= 1'b1;
                    end
                end

                S_UP: begin
                    if (r_timer == '0) begin
                        cur_floor <= w_floor_up;
                        if (w_floor_up == r_tgt) begin
                            r_state   <= S_DOOR;
                            r_timer   <= c_door_load;
                            moving_up <= 1'b0;
                            door_open <= 1'b1;
                        end else begin
                            r_timer <= c_travel_load;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                S_DOWN: begin
                    if (r_timer == '0) begin
                        cur_floor <= w_floor_dn;
                        if (w_floor_dn == r_tgt) begin
                            r_state     <= S_DOOR;
                            r_timer     <= c_door_load;
                            moving_down <= 1'b0;
                            door_open   <= 1'b1;
                        end else begin
                            r_timer <= c_travel_load;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                S_DOOR: begin
`ifdef DISPATCH_DOOR_HOLD_EN
                    if (door_hold) begin
                        r_timer <= c_door_load;
                    end else
`endif
                    if (r_timer == '0) begin
                        r_state   <= S_POP;
                        door_open <= 1'b0;
                        q_shift   <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                // q_shift was raised on entry; the default above drops it again.
                S_POP: begin
                    r_state <= S_SETTLE;
                end

                // Gives the queue a cycle to present the new head before sampling.
                S_SETTLE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state     <= S_IDLE;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                    door_open   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_elevator_queue_dispatcher.sv
// ============================================================================
// Module   : tb_elevator_queue_dispatcher
// Purpose  : Self-checking bench for elevator_queue_dispatcher. A queue model
//            feeds the head word; each accepted request is expanded into its
//            expected per-cycle output timeline (decide, travel, door, pop,
//            settle, idle) and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_queue_dispatcher;

    localparam int TRAVEL = 4;
    localparam int DOORC  = 3;
    localparam int MAXF   = 12;
    localparam int RSTF   = 1;

    logic       clk;
    logic       reset;
    logic [3:0] q_data;
    logic [3:0] q_addr;
    logic       q_shift;
    logic [3:0] cur_floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       busy;
    logic       req_drop;
`ifdef DISPATCH_DOOR_HOLD_EN
    logic       door_hold;
`endif

    elevator_queue_dispatcher #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOORC),
        .MAX_FLOOR     (MAXF),
        .RESET_FLOOR   (RSTF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef DISPATCH_DOOR_HOLD_EN
        .door_hold   (door_hold),
`endif
        .q_data      (q_data),
        .q_addr      (q_addr),
        .q_shift     (q_shift),
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .busy        (busy),
        .req_drop    (req_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: floor, up, down, door, shift, drop, busy, addr.
    logic [13:0] act;
    assign act = {cur_floor, moving_up, moving_down, door_open, q_shift, req_drop, busy, q_addr};

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_q[$];
    logic [13:0] trace[$];
    int          m_floor;
    int          n_shift_seen = 0;
    int          n_exp_pops = 0;
    logic        prev_shift = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] mk(input int f, input bit up, input bit dn, input bit dr,
                                       input bit sh, input bit drop, input bit bsy);
        return {4'(f), up, dn, dr, sh, drop, bsy, 4'd0};
    endfunction

    task automatic drive_q();
        q_data = (m_q.size() != 0) ? 4'(m_q[0]) : 4'd0;
    endtask

    task automatic push(input int v);
        m_q.push_back(v);
        drive_q();
    endtask

    // Expand one accepted head into the cycle-by-cycle outputs it should produce.
    task automatic plan(input int h);
        int f;
        f = m_floor;
        trace.push_back(mk(f, 0, 0, 0, 0, 0, 1));
        if (h > MAXF) begin
            trace.push_back(mk(f, 0, 0, 0, 1, 1, 1));
        end else begin
            while (f != h) begin
                for (int i = 0; i < TRAVEL; i++)
                    trace.push_back(mk(f, h > f, h < f, 0, 0, 0, 1));
                f = (h > f) ? f + 1 : f - 1;
            end
            for (int i = 0; i < DOORC; i++)
                trace.push_back(mk(h, 0, 0, 1, 0, 0, 1));
            trace.push_back(mk(h, 0, 0, 0, 1, 0, 1));
            m_floor = h;
        end
        trace.push_back(mk(m_floor, 0, 0, 0, 0, 0, 1));
        trace.push_back(mk(m_floor, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        logic [13:0] e;
        if (trace.size() == 0 && m_q.size() != 0) plan(m_q[0]);
        @(posedge clk);
        #1;
        e = (trace.size() != 0) ? trace.pop_front() : mk(m_floor, 0, 0, 0, 0, 0, 0);
        check("outputs", 32'(act), 32'(e));
        check("excl", 32'($countones({moving_up, moving_down, door_open}) <= 1), 32'd1);
        check("shift_adj", 32'(prev_shift & q_shift), 32'd0);
        prev_shift = q_shift;
        if (q_shift) n_shift_seen++;
        if (e[6]) begin
            void'(m_q.pop_front());
            n_exp_pops++;
            drive_q();
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((trace.size() != 0 || m_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(trace.size() + m_q.size()), 32'd0);
    endtask

    // Asserts reset between edges and checks the asynchronous clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(act), 32'(mk(RSTF, 0, 0, 0, 0, 0, 0)));
        trace.delete();
        m_floor    = RSTF;
        prev_shift = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        int s0;
        reset   = 1'b1;
        q_data  = 4'd0;
        m_floor = RSTF;
`ifdef DISPATCH_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        #13;
        check("reset_state", 32'(act), 32'(mk(RSTF, 0, 0, 0, 0, 0, 0)));
        #5;
        reset = 1'b0;
        repeat (2) tick();

        // Up trip, down trip, same floor, invalid head.
        push(4);  drain(200);
        check("floor_after_up", 32'(cur_floor), 32'd4);
        push(2);  drain(200);
        check("floor_after_down", 32'(cur_floor), 32'd2);
        push(2);  drain(200);
        push(14); drain(200);
        check("floor_after_drop", 32'(cur_floor), 32'd2);

        // Back-to-back heads must yield exactly two pops.
        s0 = n_shift_seen;
        push(3); push(1); drain(300);
        check("b2b_pops", 32'(n_shift_seen - s0), 32'd2);

        // Reset in the middle of an up trip; the head is served again afterwards.
        push(9);
        repeat (6) tick();
        do_reset();
        drain(300);
        check("floor_after_reserve", 32'(cur_floor), 32'd9);

        // Randomised traffic with occasional mid-operation resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0 && m_q.size() < 16) push(int'($urandom_range(1, 15)));
            if ($urandom_range(0, 599) == 0) do_reset();
            tick();
        end
        drain(3000);
        repeat (3) tick();
        check("pop_count", 32'(n_shift_seen), 32'(n_exp_pops));
        check("idle_at_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
